// File: rtl/qbert_rom_loader_pkg.sv
// Shared types and constants for the Q*bert ROM loader: FSM states, the
// address-region decode and the default stream/size constants.
package qbert_rom_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {REG_MAIN, REG_SND, REG_NONE} region_t;

  localparam logic [7:0] ROM_INDEX_DEF  = 8'd0;
  localparam logic [7:0] DIP_INDEX_DEF  = 8'd254;
  localparam int         MAIN_BYTES_DEF = 65536;
  localparam int         SND_BYTES_DEF  = 8192;
  localparam int         CNT_W          = 18;

  // Classify a stream offset into the board it belongs to.
  function automatic region_t decode_region(input logic [24:0] addr,
                                            input logic [24:0] main_end,
                                            input logic [24:0] total_end);
    region_t reg_sel;
    if (addr < main_end)       reg_sel = REG_MAIN;
    else if (addr < total_end) reg_sel = REG_SND;
    else                       reg_sel = REG_NONE;
    return reg_sel;
  endfunction

endpackage

// File: rtl/qbert_rom_loader_if.sv
// Bundle of the ioctl download port, both board write ports and the status
// outputs. The loader uses the slave modport, the surrounding system the
// master modport. ROM_CHECKSUM_EN adds the rom_sum signal.
interface qbert_rom_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        main_valid;
  logic        main_ready;
  logic [15:0] main_addr;
  logic        snd_valid;
  logic        snd_ready;
  logic [12:0] snd_addr;
  logic [7:0]  rom_data;
  logic [63:0] dip_sw;
  logic        rom_loaded;
  logic        rom_short;
  logic        rom_ovf;
  logic        rom_drop;
`ifdef ROM_CHECKSUM_EN
  logic [15:0] rom_sum;

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  main_ready, snd_ready,
    output ioctl_wait, main_valid, main_addr, snd_valid, snd_addr, rom_data,
    output dip_sw, rom_loaded, rom_short, rom_ovf, rom_drop, rom_sum
  );

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output main_ready, snd_ready,
    input  ioctl_wait, main_valid, main_addr, snd_valid, snd_addr, rom_data,
    input  dip_sw, rom_loaded, rom_short, rom_ovf, rom_drop, rom_sum
  );
`else
  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  main_ready, snd_ready,
    output ioctl_wait, main_valid, main_addr, snd_valid, snd_addr, rom_data,
    output dip_sw, rom_loaded, rom_short, rom_ovf, rom_drop
  );

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output main_ready, snd_ready,
    input  ioctl_wait, main_valid, main_addr, snd_valid, snd_addr, rom_data,
    input  dip_sw, rom_loaded, rom_short, rom_ovf, rom_drop
  );
`endif
endinterface

// File: rtl/qbert_rom_loader_dip_latch.sv
// DIP switch store: eight byte registers, one per DIP byte, written by the
// decoded DIP-stream strobe. Survives ROM loads; cleared only by reset.
module qbert_dip_latch (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        i_we,
  input  logic [2:0]  i_sel,
  input  logic [7:0]  i_data,
  output logic [63:0] o_dip_sw
);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_byte
      logic [7:0] r_byte;

      // Capture the byte addressed by the DIP write.
      always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)                             r_byte <= 8'h00;
        else if (i_we && (i_sel == 3'(gi)))    r_byte <= i_data;
      end

      assign o_dip_sw[8*gi +: 8] = r_byte;
    end
  endgenerate

endmodule

// File: rtl/qbert_rom_loader.sv
// Q*bert ROM loader: splits the index-0 ioctl stream into main-board and
// sound-board write streams with a 1-deep output stage plus 1-entry skid,
// backpressures hps_io via ioctl_wait, latches DIP bytes and reports status.
// Optional feature macro: ROM_CHECKSUM_EN (adds rom_sum).
module qbert_rom_loader
  import qbert_rom_pkg::*;
#(
  parameter int         MAIN_BYTES = MAIN_BYTES_DEF,
  parameter int         SND_BYTES  = SND_BYTES_DEF,
  parameter logic [7:0] ROM_INDEX  = ROM_INDEX_DEF,
  parameter logic [7:0] DIP_INDEX  = DIP_INDEX_DEF
) (
  input logic               clk_sys,
  input logic               reset,
  qbert_rom_loader_if.slave bus
);

  localparam logic [24:0]      LP_MAIN_END  = 25'(MAIN_BYTES);
  localparam logic [24:0]      LP_TOTAL_END = 25'(MAIN_BYTES + SND_BYTES);
  localparam logic [CNT_W-1:0] LP_TOTAL_CNT = CNT_W'(MAIN_BYTES + SND_BYTES);

  state_t           r_state, w_state_next;
  logic             r_dl_prev;
  logic             r_out_valid, r_skid_valid;
  region_t          r_out_region, r_skid_region;
  logic [15:0]      r_out_off, r_skid_off;
  logic [7:0]       r_out_data, r_skid_data;
  logic [CNT_W-1:0] r_count;
  logic             r_loaded, r_short, r_ovf, r_drop;

  logic             w_start, w_rom_wr, w_in_range, w_xfer, w_out_free;
  logic             w_to_out, w_to_skid, w_drop, w_accept, w_drained;
  logic             w_load_entry, w_done_entry;
  region_t          w_region;
  logic [15:0]      w_off;

  assign w_start    = bus.ioctl_download && !r_dl_prev && (bus.ioctl_index == ROM_INDEX);
  assign w_rom_wr   = (r_state == LOAD) && bus.ioctl_wr && (bus.ioctl_index == ROM_INDEX);
  assign w_region   = decode_region(bus.ioctl_addr, LP_MAIN_END, LP_TOTAL_END);
  assign w_in_range = w_rom_wr && (w_region != REG_NONE);
  // Sound offsets are rebased to the start of the sound region.
  assign w_off      = bus.ioctl_addr[15:0] - ((w_region == REG_SND) ? LP_MAIN_END[15:0] : 16'd0);

  assign w_xfer     = r_out_valid && (((r_out_region == REG_MAIN) && bus.main_ready) ||
                                      ((r_out_region == REG_SND)  && bus.snd_ready));
  assign w_out_free = !r_out_valid || w_xfer;
  // A full skid loses the byte even if the out-stage drains this cycle:
  // hps_io was already told to wait.
  assign w_drop     = w_in_range && r_skid_valid;
  assign w_to_out   = w_in_range && !r_skid_valid && w_out_free;
  assign w_to_skid  = w_in_range && !r_skid_valid && !w_out_free;
  assign w_accept   = w_to_out || w_to_skid;
  assign w_drained  = !r_out_valid && !r_skid_valid;

  // State register and download-edge history. The edge detector resets
  // high so a download still asserted across a reset does not restart a load.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_dl_prev <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_dl_prev <= bus.ioctl_download;
    end
  end

  // Next-state decode with load-entry and done-entry events.
  always_comb begin
    w_state_next = r_state;
    w_load_entry = 1'b0;
    w_done_entry = 1'b0;
    case (r_state)
      IDLE, DONE: if (w_start) begin
        w_state_next = LOAD;
        w_load_entry = 1'b1;
      end
      LOAD:       if (!bus.ioctl_download) w_state_next = DRAIN;
      DRAIN:      if (w_drained) begin
        w_state_next = DONE;
        w_done_entry = 1'b1;
      end
      default:    w_state_next = IDLE;
    endcase
  end

  // Out-stage and skid: the skid always refills the out-stage first so
  // bytes leave in arrival order.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_out_valid   <= 1'b0;
      r_out_region  <= REG_NONE;
      r_out_off     <= '0;
      r_out_data    <= '0;
      r_skid_valid  <= 1'b0;
      r_skid_region <= REG_NONE;
      r_skid_off    <= '0;
      r_skid_data   <= '0;
    end else begin
      if (w_out_free) begin
        if (r_skid_valid) begin
          r_out_valid  <= 1'b1;
          r_out_region <= r_skid_region;
          r_out_off    <= r_skid_off;
          r_out_data   <= r_skid_data;
          r_skid_valid <= 1'b0;
        end else if (w_to_out) begin
          r_out_valid  <= 1'b1;
          r_out_region <= w_region;
          r_out_off    <= w_off;
          r_out_data   <= bus.ioctl_dout;
        end else begin
          r_out_valid  <= 1'b0;
        end
      end
      if (w_to_skid) begin
        r_skid_valid  <= 1'b1;
        r_skid_region <= w_region;
        r_skid_off    <= w_off;
        r_skid_data   <= bus.ioctl_dout;
      end
    end
  end

  // Accepted-byte counter and sticky status flags.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_loaded <= 1'b0;
      r_short  <= 1'b0;
      r_ovf    <= 1'b0;
      r_drop   <= 1'b0;
    end else if (w_load_entry) begin
      r_count  <= '0;
      r_loaded <= 1'b0;
      r_short  <= 1'b0;
      r_ovf    <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      if (w_accept && (r_count != '1)) r_count <= r_count + 1'b1;
      if (w_rom_wr && (w_region == REG_NONE)) r_ovf <= 1'b1;
      if (w_drop) r_drop <= 1'b1;
      if (w_done_entry) begin
        r_loaded <= (r_count == LP_TOTAL_CNT);
        r_short  <= (r_count != LP_TOTAL_CNT);
      end
    end
  end

`ifdef ROM_CHECKSUM_EN
  logic [15:0] r_sum;

  // Running sum of bytes actually delivered to a board.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)             r_sum <= '0;
    else if (w_load_entry) r_sum <= '0;
    else if (w_xfer)       r_sum <= r_sum + 16'(r_out_data);
  end

  assign bus.rom_sum = r_sum;
`endif

  qbert_dip_latch u_dip (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .i_we     (bus.ioctl_wr && (bus.ioctl_index == DIP_INDEX) && (bus.ioctl_addr[24:3] == '0)),
    .i_sel    (bus.ioctl_addr[2:0]),
    .i_data   (bus.ioctl_dout),
    .o_dip_sw (bus.dip_sw)
  );

  assign bus.ioctl_wait = r_skid_valid;
  assign bus.main_valid = r_out_valid && (r_out_region == REG_MAIN);
  assign bus.snd_valid  = r_out_valid && (r_out_region == REG_SND);
  assign bus.main_addr  = r_out_off;
  assign bus.snd_addr   = r_out_off[12:0];
  assign bus.rom_data   = r_out_data;
  assign bus.rom_loaded = r_loaded;
  assign bus.rom_short  = r_short;
  assign bus.rom_ovf    = r_ovf;
  assign bus.rom_drop   = r_drop;

endmodule

// File: tb/tb_qbert_rom_loader.sv
// Scoreboard bench for qbert_rom_loader: expected board writes are queued
// when a ROM byte is strobed and popped as the DUT hands them to a board.
// Build with ROM_CHECKSUM_EN defined to also check rom_sum.
module tb_qbert_rom_loader;
  localparam int TOTAL = 73728;
  localparam int MAIN_B = 65536;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  qbert_rom_loader_if bus();

  qbert_rom_loader dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  wr_t         main_q[$];
  wr_t         snd_q[$];
  int          wait_cnt = 0;
  logic [15:0] sum_model = '0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every board handshake is matched against the scoreboard.
  always @(negedge clk_sys) begin
    wr_t e;
    if (!reset) begin
      if (bus.main_valid && bus.snd_valid) check_val("both_valid", 1, 0);
      if (bus.ioctl_wait) wait_cnt++;
      if (bus.main_valid && bus.main_ready) begin
        if (main_q.size() == 0) check_val("main_unexpected_write", {bus.main_addr, bus.rom_data}, 0);
        else begin
          e = main_q.pop_front();
          check_val("main_addr", bus.main_addr, e.addr);
          check_val("main_data", bus.rom_data, e.data);
          sum_model += 16'(e.data);
        end
      end
      if (bus.snd_valid && bus.snd_ready) begin
        if (snd_q.size() == 0) check_val("snd_unexpected_write", {bus.snd_addr, bus.rom_data}, 0);
        else begin
          e = snd_q.pop_front();
          check_val("snd_addr", bus.snd_addr, e.addr);
          check_val("snd_data", bus.rom_data, e.data);
          sum_model += 16'(e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic dl_start(input logic [7:0] idx);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    tick();
  endtask

  task automatic dl_end();
    bus.ioctl_download = 1'b0;
    tick();
  endtask

  // One strobe; when expect_out is set the byte must later reach a board.
  task automatic rom_wr(input logic [24:0] a, input logic [7:0] d, input bit expect_out);
    wr_t e;
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    if (expect_out) begin
      e.data = d;
      if (a < 25'(MAIN_B)) begin
        e.addr = a[15:0];
        main_q.push_back(e);
      end else begin
        e.addr = 16'(a - 25'(MAIN_B));
        snd_q.push_back(e);
      end
    end
    tick();
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((main_q.size() != 0 || snd_q.size() != 0) && k < 500) begin
      tick();
      k++;
    end
    check_val(tag, (k >= 500), 0);
    repeat (4) tick();
  endtask

  initial begin
    int          wait_base;
    logic [15:0] sum_base;
    logic [63:0] dip_exp;

    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.main_ready     = 1'b1;
    bus.snd_ready      = 1'b1;
    repeat (3) tick();
    check_val("reset_flags", {bus.main_valid, bus.snd_valid, bus.ioctl_wait, bus.rom_loaded,
                              bus.rom_short, bus.rom_ovf, bus.rom_drop}, 0);
    check_val("reset_dip", bus.dip_sw, 0);
    reset = 1'b0;
    tick();

    // T1: whole image, readies held high.
    wait_base = wait_cnt;
    sum_base  = sum_model;
    dl_start(8'd0);
    for (int a = 0; a < TOTAL; a++) rom_wr(25'(a), 8'(a ^ (a >> 8)), 1'b1);
    dl_end();
    drain("t1_drain");
    check_val("t1_loaded", bus.rom_loaded, 1);
    check_val("t1_short", bus.rom_short, 0);
    check_val("t1_ovf_drop", {bus.rom_ovf, bus.rom_drop}, 0);
    check_val("t1_wait_cycles", wait_cnt - wait_base, 0);
`ifdef ROM_CHECKSUM_EN
    check_val("t1_sum", bus.rom_sum, 16'(sum_model - sum_base));
`endif

    // T2: stall, two strobes -> second waits in the skid.
    dl_start(8'd0);
    check_val("t2_loaded_cleared", bus.rom_loaded, 0);
    bus.main_ready = 1'b0;
    rom_wr(25'd10, 8'h3C, 1'b1);
    rom_wr(25'd11, 8'hC3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_val("t2_wait_high", bus.ioctl_wait, 1);
      check_val("t2_addr_held", bus.main_addr, 10);
      check_val("t2_data_held", bus.rom_data, 8'h3C);
      tick();
    end
    bus.main_ready = 1'b1;
    tick();
    check_val("t2_wait_low", bus.ioctl_wait, 0);
    check_val("t2_skid_out", bus.main_addr, 11);
    tick();

    // T3: third strobe with the skid full is discarded.
    bus.main_ready = 1'b0;
    rom_wr(25'd20, 8'h20, 1'b1);
    rom_wr(25'd21, 8'h21, 1'b1);
    rom_wr(25'd22, 8'h77, 1'b0);
    check_val("t3_drop", bus.rom_drop, 1);
    bus.main_ready = 1'b1;
    drain("t3_drain");
    dl_end();
    repeat (3) tick();
    check_val("t3_short", bus.rom_short, 1);

    // T4: short load plus an out-of-range offset.
    dl_start(8'd0);
    check_val("t4_flags_cleared", {bus.rom_short, bus.rom_drop}, 0);
    for (int a = 0; a < 100; a++) rom_wr(25'(a), ~8'(a), 1'b1);
    rom_wr(25'h12000, 8'h55, 1'b0);
    check_val("t4_ovf", bus.rom_ovf, 1);
    dl_end();
    drain("t4_drain");
    check_val("t4_short_loaded", {bus.rom_short, bus.rom_loaded}, 2'b10);
    check_val("t4_ovf_sticky", bus.rom_ovf, 1);

    // T5: DIP bytes, out-of-window DIP address, foreign index.
    dl_start(8'd254);
    rom_wr(25'd3, 8'hA5, 1'b0);
    dip_exp = 64'h0000_0000_A500_0000;
    check_val("t5_dip3", bus.dip_sw, dip_exp);
    check_val("t5_dip_wait", bus.ioctl_wait, 0);
    rom_wr(25'd8, 8'hFF, 1'b0);
    check_val("t5_dip8_ignored", bus.dip_sw, dip_exp);
    rom_wr(25'd0, 8'h12, 1'b0);
    dip_exp = 64'h0000_0000_A500_0012;
    check_val("t5_dip0", bus.dip_sw, dip_exp);
    dl_end();
    dl_start(8'd7);
    rom_wr(25'd5, 8'h99, 1'b0);
    check_val("t5_foreign_wait", bus.ioctl_wait, 0);
    dl_end();
    dl_start(8'd0);
    for (int a = 0; a < 3; a++) rom_wr(25'(a), 8'(a + 1), 1'b1);
    dl_end();
    drain("t5_drain");
    check_val("t5_dip_retained", bus.dip_sw, dip_exp);

    // T6: reset while a sound write is stalled.
    dl_start(8'd0);
    bus.snd_ready = 1'b0;
    rom_wr(25'h10005, 8'h5A, 1'b1);
    check_val("t6_snd_valid", bus.snd_valid, 1);
    check_val("t6_snd_addr", bus.snd_addr, 5);
    reset = 1'b1;
    #2;
    check_val("t6_reset_flags", {bus.main_valid, bus.snd_valid, bus.ioctl_wait, bus.rom_loaded,
                                 bus.rom_short, bus.rom_ovf, bus.rom_drop}, 0);
    check_val("t6_reset_bus", {bus.rom_data, bus.snd_addr, bus.main_addr}, 0);
    check_val("t6_reset_dip", bus.dip_sw, 0);
    snd_q.delete();
    bus.ioctl_download = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    bus.snd_ready = 1'b1;
    repeat (3) tick();
    check_val("t6_no_write_after_reset", {bus.main_valid, bus.snd_valid}, 0);
    sum_base = sum_model;
    dl_start(8'd0);
    rom_wr(25'd0, 8'h11, 1'b1);
    rom_wr(25'd1, 8'h22, 1'b1);
    dl_end();
    drain("t6_drain");
    check_val("t6_short", {bus.rom_short, bus.rom_loaded, bus.rom_drop}, 3'b100);
`ifdef ROM_CHECKSUM_EN
    check_val("t6_sum", bus.rom_sum, 16'(sum_model - sum_base));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
